// File: rtl/gate_sweep_ctrl_if.sv
// gate_sweep_ctrl_if: signal bundle between the sweep controller and its
// environment (requester plus the complex gate under test).
//
// Handshake: 'start' is a level request. It has no ready/ack; it is only
// acted on while the controller is idle or done, and 'busy'/'done' report
// where the sweep is. 'vec' drives the gate, and 'dut_y' is the gate's
// combinational response to it. The result outputs are stable whenever
// 'done' is high.
interface gate_sweep_ctrl_if;
  logic       start;
  logic       dut_y;
  logic [5:0] vec;
  logic       busy;
  logic       done;
  logic       pass;
  logic [6:0] err_count;
  logic       fail_valid;
  logic [5:0] fail_vec;

  // Controller side
  modport master (
    input  start,
    input  dut_y,
    output vec,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_valid,
    output fail_vec
  );

  // Requester / gate-under-test side
  modport slave (
    output start,
    output dut_y,
    input  vec,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_valid,
    input  fail_vec
  );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: exhaustive functional test of one complex gate,
//   Y = ~((A|B) & ((C&D)|(E&F)))
// Walks vec = {A,B,C,D,E,F} through 0..63. Each vector settles for
// SETTLE_CYCLES cycles and is then sampled for one cycle, so every vector
// is held for SETTLE_CYCLES+1 cycles. Mismatches are counted and the first
// failing vector is recorded.
//
// Optional build macro FAIL_HALT_EN: when defined, the first mismatch ends
// the sweep immediately and vec stays on the failing vector.
module gate_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  logic               clk,
  input  logic               rst_n,
  gate_sweep_ctrl_if.master  sweep_if,
  output logic [1:0]         state_o   // debug view of the FSM state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Counter load value: SETTLE lasts SETTLE_CYCLES cycles because it leaves
  // on the edge at which the counter is already zero.
  localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);

`ifdef FAIL_HALT_EN
  localparam bit HALT_ON_FAIL = 1'b1;
`else
  localparam bit HALT_ON_FAIL = 1'b0;
`endif

  state_t     state_q, state_d;
  logic [5:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] err_q, err_d;
  logic       fv_q, fv_d;
  logic [5:0] fvec_q, fvec_d;

  // Golden response of the gate for the vector currently applied
  logic exp_y;
  logic mismatch;

  assign exp_y    = ~((vec_q[5] | vec_q[4]) &
                      ((vec_q[3] & vec_q[2]) | (vec_q[1] & vec_q[0])));
  assign mismatch = (state_q == SAMPLE) && (sweep_if.dut_y != exp_y);

  // State and result registers; reset drops everything, including any
  // partial sweep results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= 6'd0;
      cnt_q   <= 4'd0;
      err_q   <= 7'd0;
      fv_q    <= 1'b0;
      fvec_q  <= 6'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fvec_d  = fvec_q;

    case (state_q)
      IDLE, DONE: begin
        // Results stay frozen here until a new start clears them.
        if (sweep_if.start) begin
          state_d = SETTLE;
          vec_d   = 6'd0;
          cnt_d   = SETTLE_RELOAD;
          err_d   = 7'd0;
          fv_d    = 1'b0;
          fvec_d  = 6'd0;
        end
      end

      SETTLE: begin
        // start is deliberately not looked at while busy.
        if (cnt_q == 4'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      SAMPLE: begin
        // The count is updated on this same edge, so a failure on the
        // last vector is already included when DONE is entered.
        if (mismatch) begin
          err_d = err_q + 7'd1;
          if (!fv_q) begin
            fv_d   = 1'b1;
            fvec_d = vec_q;
          end
        end

        if (HALT_ON_FAIL && mismatch) begin
          // Only the first mismatch can get here: it stops the sweep.
          state_d = DONE;
        end else if (vec_q == 6'd63) begin
          // vec holds at 63; it never wraps.
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 6'd1;
          cnt_d   = SETTLE_RELOAD;
          state_d = SETTLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode straight from registers, so reset clears them at once
  assign sweep_if.vec        = vec_q;
  assign sweep_if.busy       = (state_q == SETTLE) || (state_q == SAMPLE);
  assign sweep_if.done       = (state_q == DONE);
  assign sweep_if.pass       = (state_q == DONE) && (err_q == 7'd0);
  assign sweep_if.err_count  = err_q;
  assign sweep_if.fail_valid = fv_q;
  assign sweep_if.fail_vec   = fvec_q;
  assign state_o             = state_q;

endmodule

// File: doc/gate_sweep_ctrl.md
GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 2, settle cycles per vector before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  sweep request; sampled only in IDLE or DONE.
REQ-005 dut_y  input  1  output Y of the complex gate under test.
REQ-006 vec  output  6  stimulus to the gate under test: vec[5]=A, vec[4]=B, vec[3]=C, vec[2]=D, vec[1]=E, vec[0]=F.
REQ-007 busy  output  1  high in SETTLE and SAMPLE.
REQ-008 done  output  1  high in DONE.
REQ-009 pass  output  1  done AND err_count==0.
REQ-010 err_count  output  7  number of mismatching vectors in the current or last sweep (0..64, no saturation needed).
REQ-011 fail_valid  output  1  at least one mismatch recorded this sweep.
REQ-012 fail_vec  output  6  first mismatching vector; valid only when fail_valid=1.

Function
REQ-013 Expected value SHALL be exp = ~((A|B) & ((C&D)|(E&F))), computed from vec.
REQ-014 FSM states SHALL be IDLE, SETTLE, SAMPLE and DONE.
REQ-015 IDLE/DONE with start=1 at an edge -> SETTLE at that edge: vec<=0, settle counter<=SETTLE_CYCLES-1, err_count<=0, fail_valid<=0, fail_vec<=0.
REQ-016 SETTLE: counter decrements each edge; at the edge where counter==0 -> SAMPLE.
REQ-017 SAMPLE lasts exactly one cycle; at its closing edge dut_y SHALL be compared with exp, and on mismatch err_count SHALL increment.
REQ-018 On the first mismatch of a sweep, fail_valid<=1 and fail_vec<=vec; later mismatches SHALL NOT change fail_vec.
REQ-019 SAMPLE exit: vec==63 -> DONE with vec held at 63; otherwise vec<=vec+1, counter reloaded, -> SETTLE. vec SHALL never wrap.
REQ-020 Each vector SHALL be held stable for exactly SETTLE_CYCLES+1 cycles; a full sweep SHALL take 64*(SETTLE_CYCLES+1) cycles from the start edge to DONE entry.
REQ-021 start in SETTLE or SAMPLE SHALL be ignored.
REQ-022 DONE SHALL hold done and all results until start (restart) or reset.
REQ-023 A mismatch on vector 63 SHALL be counted before DONE is entered, so results are complete when done first rises.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE: vec=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0, counter=0.
REQ-025 Reset during a sweep SHALL discard partial results; a new start is required after release.

Configuration
REQ-026 Macro FAIL_HALT_EN defined: the first mismatch SHALL move the FSM from SAMPLE directly to DONE, vec held at the failing vector, err_count=1.
REQ-027 FAIL_HALT_EN undefined: all 64 vectors SHALL always be swept regardless of mismatches.

Verification
REQ-028 Correct gate model, SETTLE_CYCLES=2, start pulse -> done rises 192 cycles after the start edge; err_count=0, pass=1, fail_valid=0.
REQ-029 dut_y stuck at 0 -> err_count=43, fail_vec=6'b000000, pass=0.
REQ-030 dut_y stuck at 1 -> err_count=21, fail_vec=6'b010011 (19), pass=0; with FAIL_HALT_EN: done after vector 19, err_count=1, vec=19.
REQ-031 rst_n pulsed low at vector 30 -> all outputs are 0 asynchronously; a subsequent start gives a complete 64-vector sweep with correct counts.
REQ-032 start held high throughout a sweep -> no restart while busy; in DONE, start restarts and err_count clears to 0 on the start edge.
